// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   pcu_state_e : sequencer state (RUN, DRAIN, HALTED)
//   REG_ZERO    : hardwired-zero register index, never a hazard source
//   pcu_ctrl_t  : bundle of per-stage write enables and flushes
package pipeline_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pcu_state_e;

    localparam logic [3:0] REG_ZERO = 4'd0;

    typedef struct packed {
        logic pc_write;
        logic fd_write;
        logic fd_flush;
        logic de_write;
        logic de_flush;
        logic xm_write;
        logic mw_write;
    } pcu_ctrl_t;

    // Control patterns, field order as in pcu_ctrl_t
    localparam pcu_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam pcu_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pcu_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pcu_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam pcu_ctrl_t CTRL_DRAIN  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam pcu_ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_control_unit_hazard_detect.sv
// hazard_detect: combinational hazard compare between F/D and D/X.
//   Inputs : D/X load/write/flag-write info and destination, F/D source
//            registers, their use flags, store and conditional-branch flags.
//   Output : stall_req - F/D must wait one cycle behind a bubble.
module hazard_detect
    import pipeline_control_unit_pkg::*;
(
    input  logic       mem_read_de,
    input  logic       reg_write_de,
    input  logic [3:0] rd_de,
    input  logic       flag_write_de,
    input  logic [3:0] rs_fd,
    input  logic [3:0] rt_fd,
    input  logic       use_rs_fd,
    input  logic       use_rt_fd,
    input  logic       store_fd,
    input  logic       cond_br_fd,
    output logic       stall_req
);

    logic load_dst;
    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic flag_hazard;

    always_comb begin
        load_dst    = mem_read_de & reg_write_de & (rd_de != REG_ZERO);
        rs_hit      = use_rs_fd & (rs_fd == rd_de);
        // Store data in rt is forwarded M->M, so it never needs the bubble
        rt_hit      = use_rt_fd & (rt_fd == rd_de) & ~store_fd;
        load_use    = load_dst & (rs_hit | rt_hit);
        flag_hazard = cond_br_fd & flag_write_de;
        stall_req   = load_use | flag_hazard;
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: stall/flush sequencer for the 5-stage pipeline.
//   Inputs : clk, rst (sync, active-high), mem_busy, D/X and F/D instruction
//            descriptors (load, writes, registers, branch, HLT).
//   Outputs: pc_write, fd_write/fd_flush, de_write/de_flush, xm_write,
//            mw_write (all same-cycle), halted, stall_count (saturating).
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_busy,
    input  logic             mem_read_de,
    input  logic             reg_write_de,
    input  logic [3:0]       rd_de,
    input  logic             flag_write_de,
    input  logic [3:0]       rs_fd,
    input  logic [3:0]       rt_fd,
    input  logic             use_rs_fd,
    input  logic             use_rt_fd,
    input  logic             store_fd,
    input  logic             cond_br_fd,
    input  logic             br_taken_fd,
    input  logic             hlt_fd,
    output logic             pc_write,
    output logic             fd_write,
    output logic             fd_flush,
    output logic             de_write,
    output logic             de_flush,
    output logic             xm_write,
    output logic             mw_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pcu_state_e         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               stall_req;
    logic               start_drain;
    pcu_ctrl_t          ctrl;

    hazard_detect u_hazard_detect (
        .mem_read_de   (mem_read_de),
        .reg_write_de  (reg_write_de),
        .rd_de         (rd_de),
        .flag_write_de (flag_write_de),
        .rs_fd         (rs_fd),
        .rt_fd         (rt_fd),
        .use_rs_fd     (use_rs_fd),
        .use_rt_fd     (use_rt_fd),
        .store_fd      (store_fd),
        .cond_br_fd    (cond_br_fd),
        .stall_req     (stall_req)
    );

    // Output priority: reset, HALTED, mem_busy freeze, then RUN events
    always_comb begin
        ctrl        = CTRL_FREEZE;
        start_drain = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_busy)         ctrl = CTRL_FREEZE;
                    else if (stall_req)   ctrl = CTRL_STALL;
                    else if (br_taken_fd) ctrl = CTRL_BRANCH;
                    else if (hlt_fd) begin
                        ctrl        = CTRL_DRAIN;
                        start_drain = 1'b1;
                    end else begin
                        ctrl = CTRL_PASS;
                    end
                end
                DRAIN:   ctrl = mem_busy ? CTRL_FREEZE : CTRL_DRAIN;
                HALTED:  ctrl = CTRL_FREEZE;
                default: ctrl = CTRL_FREEZE;
            endcase
        end
    end

    always_comb begin
        pc_write = ctrl.pc_write;
        fd_write = ctrl.fd_write;
        fd_flush = ctrl.fd_flush;
        de_write = ctrl.de_write;
        de_flush = ctrl.de_flush;
        xm_write = ctrl.xm_write;
        mw_write = ctrl.mw_write;
        halted   = ~rst & (state == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            // Every RUN cycle with the PC held counts, including mem_busy and HLT
            if ((state == RUN) && !ctrl.pc_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            unique case (state)
                RUN: begin
                    if (start_drain) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == '0) state <= HALTED;
                        else                 drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Testbench for pipeline_control_unit: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_pipeline_control_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_busy, mem_read_de, reg_write_de, flag_write_de;
    logic [3:0]  rd_de, rs_fd, rt_fd;
    logic        use_rs_fd, use_rt_fd, store_fd, cond_br_fd, br_taken_fd, hlt_fd;
    logic        pc_write, fd_write, fd_flush, de_write, de_flush, xm_write, mw_write, halted;
    logic [15:0] stall_count;
    logic [7:0]  obs;

    // Small-counter instance for saturation
    logic        rst_s, busy_s;
    logic        s_pc, s_fd, s_fdf, s_de, s_def, s_xm, s_mw, s_h;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;

    pipeline_control_unit #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_busy(mem_busy), .mem_read_de(mem_read_de),
        .reg_write_de(reg_write_de), .rd_de(rd_de), .flag_write_de(flag_write_de),
        .rs_fd(rs_fd), .rt_fd(rt_fd), .use_rs_fd(use_rs_fd), .use_rt_fd(use_rt_fd),
        .store_fd(store_fd), .cond_br_fd(cond_br_fd), .br_taken_fd(br_taken_fd),
        .hlt_fd(hlt_fd), .pc_write(pc_write), .fd_write(fd_write), .fd_flush(fd_flush),
        .de_write(de_write), .de_flush(de_flush), .xm_write(xm_write), .mw_write(mw_write),
        .halted(halted), .stall_count(stall_count)
    );

    pipeline_control_unit #(.DRAIN_CYCLES(3), .CNT_W(4)) sat_dut (
        .clk(clk), .rst(rst_s), .mem_busy(busy_s), .mem_read_de(1'b0),
        .reg_write_de(1'b0), .rd_de(4'd0), .flag_write_de(1'b0),
        .rs_fd(4'd0), .rt_fd(4'd0), .use_rs_fd(1'b0), .use_rt_fd(1'b0),
        .store_fd(1'b0), .cond_br_fd(1'b0), .br_taken_fd(1'b0),
        .hlt_fd(1'b0), .pc_write(s_pc), .fd_write(s_fd), .fd_flush(s_fdf),
        .de_write(s_de), .de_flush(s_def), .xm_write(s_xm), .mw_write(s_mw),
        .halted(s_h), .stall_count(sat_count)
    );

    assign obs = {pc_write, fd_write, fd_flush, de_write, de_flush, xm_write, mw_write, halted};

    typedef struct packed {
        logic rst, busy, ld, rw;
        logic [3:0] rd;
        logic fw;
        logic [3:0] rs, rt;
        logic urs, urt, st, cb, bt, hlt;
    } stim_t;

    // Expected patterns {pc,fd,fd_flush,de,de_flush,xm,mw,halted}
    localparam logic [7:0] E_RESET  = 8'b0010_1000;
    localparam logic [7:0] E_HALTED = 8'b0000_0001;
    localparam logic [7:0] E_FREEZE = 8'b0000_0000;
    localparam logic [7:0] E_DRAIN  = 8'b0111_0110;
    localparam logic [7:0] E_STALL  = 8'b0001_1110;
    localparam logic [7:0] E_BRANCH = 8'b1111_0110;
    localparam logic [7:0] E_PASS   = 8'b1101_0110;

    // Reference model: pipeline mode, remaining drain cycles, stalled-PC cycles
    int m_mode   = 0;   // 0 running, 1 draining, 2 halted
    int m_left   = 0;
    int m_stalls = 0;

    function automatic stim_t mk(input bit r, input bit b, input bit ld, input bit rw,
                                 input int rd, input bit fw, input int rs, input int rt,
                                 input bit urs, input bit urt, input bit st,
                                 input bit cb, input bit bt, input bit hlt);
        stim_t s;
        s.rst = r; s.busy = b; s.ld = ld; s.rw = rw; s.rd = 4'(rd); s.fw = fw;
        s.rs = 4'(rs); s.rt = 4'(rt); s.urs = urs; s.urt = urt; s.st = st;
        s.cb = cb; s.bt = bt; s.hlt = hlt;
        return s;
    endfunction

    function automatic bit hazard(input stim_t s);
        bit load_use, flags;
        load_use = s.ld && s.rw && (s.rd != 0) &&
                   ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd && !s.st));
        flags    = s.cb && s.fw;
        return load_use || flags;
    endfunction

    function automatic logic [7:0] model_outs(input stim_t s);
        if (s.rst)          return E_RESET;
        if (m_mode == 2)    return E_HALTED;
        if (s.busy)         return E_FREEZE;
        if (m_mode == 1)    return E_DRAIN;
        if (hazard(s))      return E_STALL;
        if (s.bt)           return E_BRANCH;
        if (s.hlt)          return E_DRAIN;
        return E_PASS;
    endfunction

    task automatic model_step(input stim_t s);
        logic [7:0] e;
        e = model_outs(s);
        if (s.rst) begin
            m_mode = 0; m_left = 0; m_stalls = 0;
        end else begin
            if (m_mode == 0 && e[7] == 1'b0 && m_stalls < 65535) m_stalls++;
            if (!s.busy) begin
                if (m_mode == 0 && e == E_DRAIN) begin
                    m_mode = 1; m_left = 3;
                end else if (m_mode == 1) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
        end
    endtask

    task automatic apply(input stim_t s);
        rst = s.rst; mem_busy = s.busy; mem_read_de = s.ld; reg_write_de = s.rw;
        rd_de = s.rd; flag_write_de = s.fw; rs_fd = s.rs; rt_fd = s.rt;
        use_rs_fd = s.urs; use_rt_fd = s.urt; store_fd = s.st;
        cond_br_fd = s.cb; br_taken_fd = s.bt; hlt_fd = s.hlt;
    endtask

    task automatic test_reset();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 1,1,3,1, 3,3, 1,1,0, 1,1,1));
        t.push_back(mk(1,1, 0,0,0,0, 0,0, 0,0,0, 0,0,1));
        t.push_back(mk(0,0, 0,0,0,0, 1,2, 1,1,0, 0,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL reset row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        t.push_back(mk(0,0, 1,1,3,0, 3,1, 1,1,0, 0,0,0)); // LW R3 ; ADD R4,R3,R1
        t.push_back(mk(0,0, 0,0,0,0, 3,1, 1,1,0, 0,0,0)); // bubble ahead of ADD
        t.push_back(mk(0,0, 1,1,3,0, 2,3, 1,1,1, 0,0,0)); // LW R3 ; SW R3 (store data)
        t.push_back(mk(0,0, 1,1,0,0, 0,0, 1,1,0, 0,0,0)); // LW R0 ; use R0
        t.push_back(mk(0,0, 1,1,5,0, 1,5, 1,1,0, 0,0,0)); // rt hit, not a store
        t.push_back(mk(0,0, 0,0,0,0, 1,5, 1,1,0, 0,0,0));
        t.push_back(mk(0,0, 1,0,5,0, 5,5, 1,1,0, 0,0,0)); // load without reg write
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL load_use row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
        checks++;
        if (stall_count !== 16'd2) begin
            errors++;
            $display("FAIL load_use_count: stall_count=%0d required 2", stall_count);
        end
    endtask

    task automatic test_flag_hazard();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        t.push_back(mk(0,0, 0,1,4,1, 0,0, 0,0,0, 1,1,0)); // ADD sets flags ; B cond taken
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 1,1,0)); // bubble ; branch resolves
        t.push_back(mk(0,0, 0,1,4,1, 0,0, 0,0,0, 0,0,0)); // flag writer, no branch
        t.push_back(mk(0,0, 0,1,4,1, 0,0, 0,0,0, 1,0,0)); // not-taken branch still waits
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 1,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL flag_hazard row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
    endtask

    task automatic test_halt_drain();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,1)); // HLT in decode
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,1)); // drain 1 (HLT ignored)
        t.push_back(mk(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0)); // memory busy, hold
        t.push_back(mk(0,0, 1,1,2,0, 2,0, 1,0,0, 0,0,0)); // drain 2 (hazard ignored)
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,0)); // drain 3
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,1,1)); // halted
        t.push_back(mk(0,1, 1,1,2,1, 2,2, 1,1,0, 1,1,1)); // halted
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL halt_drain row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
        checks++;
        if (halted !== 1'b1 || obs !== E_HALTED) begin
            errors++;
            $display("FAIL halt_final: outs=%b required %b", obs, E_HALTED);
        end
    endtask

    task automatic test_busy_load_use();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        for (int k = 0; k < 5; k++) t.push_back(mk(0,1, 1,1,7,0, 7,0, 1,0,0, 0,0,0));
        t.push_back(mk(0,0, 1,1,7,0, 7,0, 1,0,0, 0,0,0));  // single bubble
        t.push_back(mk(0,0, 0,0,0,0, 7,0, 1,0,0, 0,0,0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL busy_load_use row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
        checks++;
        if (stall_count !== 16'd6) begin
            errors++;
            $display("FAIL busy_count: stall_count=%0d required 6", stall_count);
        end
    endtask

    task automatic test_reset_in_drain();
        stim_t t[$];
        logic [7:0] e;
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        t.push_back(mk(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0,0)); // counted busy cycle
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,1)); // HLT
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0)); // draining
        t.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0)); // reset mid-drain
        t.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0)); // running again
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = model_outs(t[i]);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL reset_in_drain row %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(t[i]); #1;
        end
        checks++;
        if (stall_count !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears: cnt=%0d halted=%b required cnt=0 halted=0",
                     stall_count, halted);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        rst_s = 1'b1; busy_s = 1'b0;
        @(posedge clk); #1;
        rst_s = 1'b0; busy_s = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            exp_cnt = (i < 15) ? i : 15;
            checks++;
            if (sat_count !== 4'(exp_cnt)) begin
                errors++;
                $display("FAIL saturation cycle %0d: cnt=%0d required %0d", i, sat_count, exp_cnt);
            end
            @(posedge clk); #1;
        end
        busy_s = 1'b0;
    endtask

    task automatic test_random();
        stim_t s;
        logic [7:0] e;
        for (int i = 0; i < 600; i++) begin
            if (i == 0) s = mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0);
            else s = mk($urandom_range(0,59) == 0, $urandom_range(0,4) == 0,
                        1'($urandom), 1'($urandom), $urandom_range(0,3), 1'($urandom),
                        $urandom_range(0,3), $urandom_range(0,3),
                        1'($urandom), 1'($urandom), $urandom_range(0,3) == 0,
                        $urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
                        $urandom_range(0,39) == 0);
            apply(s);
            @(negedge clk);
            e = model_outs(s);
            checks++;
            if (obs !== e || stall_count !== 16'(m_stalls)) begin
                errors++;
                $display("FAIL random cycle %0d: outs=%b cnt=%0d required outs=%b cnt=%0d",
                         i, obs, stall_count, e, m_stalls);
            end
            @(posedge clk); model_step(s); #1;
        end
    endtask

    initial begin
        apply(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        rst_s = 1'b1; busy_s = 1'b0;
        @(posedge clk); #1;
        model_step(mk(1,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0));
        test_reset();
        test_load_use();
        test_flag_hazard();
        test_halt_drain();
        test_busy_load_use();
        test_reset_in_drain();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
